// File: rtl/arith_ext_pkg.sv
// arith_ext_pkg: shared definitions for the arithmetic-extension arbiter.
// Holds the datapath width, the requester opcode encoding and the
// arbiter FSM state type.
package arith_ext_pkg;

    localparam int DATA_W = 8;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_SQRT = 2'b01;
    localparam logic [1:0] OP_SQR  = 2'b10;
    localparam logic [1:0] OP_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

endpackage

// File: rtl/mul.sv
// mul: combinational unsigned multiplier of the arithmetic extension.
// Ports:
//   a, b - DATA_W-bit operands
//   p    - full 2*DATA_W-bit product
module mul
    import arith_ext_pkg::*;
(
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [2*DATA_W-1:0] p
);

    assign p = (2*DATA_W)'(a) * (2*DATA_W)'(b);

endmodule

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant logic.
// Ports:
//   valid0, valid1 - requester valids
//   rr_last        - id of the requester granted last time
//   grant          - id of the requester granted now
//   grant_valid    - at least one requester is valid
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic rr_last,
    output logic grant,
    output logic grant_valid
);

    always_comb begin
        grant_valid = valid0 | valid1;
        // On contention the requester that did not win last time goes first.
        if (valid0 && valid1) begin
            grant = ~rr_last;
        end else begin
            grant = valid1;
        end
    end

endmodule

// File: rtl/sqrt.sv
// sqrt: combinational integer square root, root = floor(sqrt(a)).
// Ports:
//   a    - DATA_W-bit radicand
//   root - DATA_W/2-bit root
module sqrt
    import arith_ext_pkg::*;
(
    input  logic [DATA_W-1:0]   a,
    output logic [DATA_W/2-1:0] root
);

    localparam int RW = DATA_W / 2;

    // Keep the largest candidate whose square does not exceed a.
    always_comb begin
        root = '0;
        for (int i = 1; i < (1 << RW); i++) begin
            if (i * i <= int'(a)) begin
                root = RW'(i);
            end
        end
    end

endmodule

// File: rtl/arith_ext_arbiter.sv
// arith_ext_arbiter: shares one mul and one sqrt unit between two
// requesters. Round-robin accept in IDLE, EXEC_CYCLES cycles in BUSY,
// then one registered, id-tagged response held in RESP until taken.
// Ports:
//   clk, rst_n             - clock, synchronous active-low reset
//   reqN_valid/ready       - request handshake, N = 0,1
//   reqN_op, reqN_a/b      - opcode and operands
//   rsp_valid/ready        - response handshake
//   rsp_id, rsp_hi/lo      - requester id, result bytes
//   rsp_carry, rsp_err     - product bit 16, illegal-opcode flag
//   stat_ops               - completed handshakes, saturating
//                            (only with ARITH_EXT_STATS_EN defined)
module arith_ext_arbiter
    import arith_ext_pkg::*;
#(
    parameter int EXEC_CYCLES = 1,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [1:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [1:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_hi,
    output logic [DATA_W-1:0] rsp_lo,
    output logic              rsp_carry,
    output logic              rsp_err
`ifdef ARITH_EXT_STATS_EN
    ,
    output logic [15:0]       stat_ops
`endif
);

    localparam int RES_W = 2 * DATA_W + 1;

    state_t                state, state_nxt;
    logic                  rr_last, grant, grant_valid;
    logic                  accept, exec_done, rsp_fire;
    logic [CNT_W-1:0]      cnt;
    logic [1:0]            op_q;
    logic [DATA_W-1:0]     a_q, b_q, mul_b;
    logic                  id_q;
    logic [2*DATA_W-1:0]   mul_p;
    logic [DATA_W/2-1:0]   sqrt_r;
    logic [RES_W-1:0]      res;
    logic                  res_err;

    rr_arb2 u_arb (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .rr_last     (rr_last),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign req0_ready = (state == IDLE) && grant_valid && !grant;
    assign req1_ready = (state == IDLE) && grant_valid && grant;
    assign accept     = req0_ready | req1_ready;
    assign exec_done  = (state == BUSY) && (cnt == '0);
    assign rsp_fire   = rsp_valid && rsp_ready;

    // SQR reuses the multiplier with both inputs tied to operand A.
    assign mul_b = (op_q == OP_SQR) ? a_q : b_q;

    mul  u_mul  (.a(a_q), .b(mul_b), .p(mul_p));
    sqrt u_sqrt (.a(a_q), .root(sqrt_r));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        res     = '0;
        res_err = 1'b0;
        unique case (op_q)
            OP_MUL, OP_SQR: res = RES_W'(mul_p);
            OP_SQRT:        res = RES_W'(sqrt_r);
            default:        res_err = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)    state_nxt = BUSY;
            BUSY:    if (exec_done) state_nxt = RESP;
            RESP:    if (rsp_fire)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_last   <= 1'b1;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_hi    <= '0;
            rsp_lo    <= '0;
            rsp_carry <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                rr_last <= grant;
                cnt     <= CNT_W'(EXEC_CYCLES - 1);
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (exec_done) begin
                rsp_valid                  <= 1'b1;
                rsp_id                     <= id_q;
                {rsp_carry, rsp_hi, rsp_lo} <= res;
                rsp_err                    <= res_err;
            end else if (rsp_fire) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    // NOTE: operand registers carry no reset; they are only read after an accept loads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= grant ? req1_op : req0_op;
            a_q  <= grant ? req1_a  : req0_a;
            b_q  <= grant ? req1_b  : req0_b;
            id_q <= grant;
        end
    end

`ifdef ARITH_EXT_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_ops <= '0;
        end else if (rsp_fire && stat_ops != 16'hFFFF) begin
            stat_ops <= stat_ops + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_arith_ext_arbiter.sv
// tb_arith_ext_arbiter: directed self-checking bench. dut runs with
// EXEC_CYCLES=1, dut4 with EXEC_CYCLES=4 for the long-latency and
// mid-operation reset cases.
module tb_arith_ext_arbiter;
    import arith_ext_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, v0, r0, v1, r1, rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_err;
    logic [1:0] op0, op1;
    logic [7:0] a0, b0, a1, b1, rsp_hi, rsp_lo;

    logic       x_rst_n, x_v0, x_r0, x_v1, x_r1, x_valid, x_ready, x_id, x_carry, x_err;
    logic [1:0] x_op0, x_op1;
    logic [7:0] x_a0, x_b0, x_a1, x_b1, x_hi, x_lo;
`ifdef ARITH_EXT_STATS_EN
    logic [15:0] stat_ops, x_stat_ops;
`endif

    arith_ext_arbiter #(.EXEC_CYCLES(1), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_ready(r0), .req0_op(op0), .req0_a(a0), .req0_b(b0),
        .req1_valid(v1), .req1_ready(r1), .req1_op(op1), .req1_a(a1), .req1_b(b1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_carry(rsp_carry), .rsp_err(rsp_err)
`ifdef ARITH_EXT_STATS_EN
        , .stat_ops(stat_ops)
`endif
    );

    arith_ext_arbiter #(.EXEC_CYCLES(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(x_rst_n),
        .req0_valid(x_v0), .req0_ready(x_r0), .req0_op(x_op0), .req0_a(x_a0), .req0_b(x_b0),
        .req1_valid(x_v1), .req1_ready(x_r1), .req1_op(x_op1), .req1_a(x_a1), .req1_b(x_b1),
        .rsp_valid(x_valid), .rsp_ready(x_ready), .rsp_id(x_id),
        .rsp_hi(x_hi), .rsp_lo(x_lo), .rsp_carry(x_carry), .rsp_err(x_err)
`ifdef ARITH_EXT_STATS_EN
        , .stat_ops(x_stat_ops)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete operation on dut with rsp_ready high; starts and ends
    // just after a rising edge with dut in IDLE.
    task automatic do_op(input string tag, input logic id, input logic [1:0] op,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] e_hi, input logic [7:0] e_lo, input logic e_err);
        int lat;
        rsp_ready = 1'b1;
        if (id) begin v1 = 1'b1; op1 = op; a1 = a; b1 = b; end
        else    begin v0 = 1'b1; op0 = op; a0 = a; b0 = b; end
        @(negedge clk);
        check({tag, ".ready"}, id ? r1 : r0, 1'b1);
        step();
        // Scramble the inputs: only accept-cycle values may matter.
        v0 = 1'b0; v1 = 1'b0; a0 = 8'hAA; b0 = 8'h55; a1 = 8'hAA; b1 = 8'h55;
        op0 = OP_ILL; op1 = OP_ILL;
        lat = 1;
        while (!rsp_valid && lat < 30) begin
            step();
            lat++;
        end
        check({tag, ".latency"}, lat, 2);
        check({tag, ".id"},      rsp_id, id);
        check({tag, ".hilo"},    {rsp_hi, rsp_lo}, {e_hi, e_lo});
        check({tag, ".carry"},   rsp_carry, 1'b0);
        check({tag, ".err"},     rsp_err, e_err);
        step();
        check({tag, ".drop"},    rsp_valid, 1'b0);
    endtask

    logic [7:0] alt_hi [4] = '{8'h00, 8'hFE, 8'h00, 8'hFE};
    logic [7:0] alt_lo [4] = '{8'hE1, 8'h01, 8'hE1, 8'h01};

    initial begin
        int  k, lat;
        logic seen;

        {v0, v1, rsp_ready, op0, op1, a0, b0, a1, b1} = '0;
        {x_v0, x_v1, x_ready, x_op0, x_op1, x_a0, x_b0, x_a1, x_b1} = '0;
        rst_n = 1'b0; x_rst_n = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("rst.rsp",   {rsp_valid, rsp_id, rsp_carry, rsp_err, rsp_hi, rsp_lo}, 0);
        check("rst.ready", {r0, r1}, 2'b00);
        step();
        rst_n = 1'b1; x_rst_n = 1'b1;

        // Single operations through dut.
        do_op("mul200x3", 1'b0, OP_MUL,  8'd200, 8'd3,  8'h02, 8'h58, 1'b0);
        do_op("sqrt200",  1'b1, OP_SQRT, 8'd200, 8'd9,  8'h00, 8'h0E, 1'b0);
        do_op("sqrt225",  1'b1, OP_SQRT, 8'd225, 8'd9,  8'h00, 8'h0F, 1'b0);
        do_op("sqrt0",    1'b1, OP_SQRT, 8'd0,   8'd9,  8'h00, 8'h00, 1'b0);
        do_op("illegal",  1'b0, OP_ILL,  8'd7,   8'd9,  8'h00, 8'h00, 1'b1);
        do_op("mul16x16", 1'b1, OP_MUL,  8'd16,  8'd16, 8'h01, 8'h00, 1'b0);

        // Both requesters valid; last winner was 1, so grants go 0,1,0,1.
        v0 = 1'b1; op0 = OP_SQR; a0 = 8'd15;  b0 = 8'h33;
        v1 = 1'b1; op1 = OP_MUL; a1 = 8'd255; b1 = 8'd255;
        rsp_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 40 && k < 4; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                check($sformatf("alt%0d.id", k),   rsp_id, k[0]);
                check($sformatf("alt%0d.hilo", k), {rsp_hi, rsp_lo}, {alt_hi[k], alt_lo[k]});
                k++;
                if (k == 4) begin v0 = 1'b0; v1 = 1'b0; end
            end
            @(posedge clk);
        end
        #1;
        check("alt.count", k, 4);

        // Backpressure: hold the response 5 cycles, then take it.
        rsp_ready = 1'b0;
        v0 = 1'b1; op0 = OP_MUL; a0 = 8'd200; b0 = 8'd3;
        step();
        v0 = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 30) begin step(); lat++; end
        v0 = 1'b1; v1 = 1'b1; op1 = OP_MUL; a1 = 8'd2; b1 = 8'd2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("hold%0d.rsp", i), {rsp_valid, rsp_id, rsp_err, rsp_carry, rsp_hi, rsp_lo},
                  {1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 8'h58});
            check($sformatf("hold%0d.ready", i), {r0, r1}, 2'b00);
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("hold.final", rsp_valid, 1'b1);
        step();
        @(negedge clk);
        check("hold.after_valid", rsp_valid, 1'b0);
        check("hold.after_ready", {r0, r1}, 2'b01);
        v0 = 1'b0; v1 = 1'b0;
        step();

        // dut4: full latency, then reset during BUSY.
        x_ready = 1'b1;
        x_v0 = 1'b1; x_op0 = OP_MUL; x_a0 = 8'd16; x_b0 = 8'd16;
        @(negedge clk);
        check("x.ready0", x_r0, 1'b1);
        step();
        x_v0 = 1'b0;
        lat = 1;
        while (!x_valid && lat < 30) begin step(); lat++; end
        check("x.latency", lat, 5);
        check("x.hilo", {x_hi, x_lo}, 16'h0100);
        step();
        check("x.drop", x_valid, 1'b0);

        x_v0 = 1'b1; x_op0 = OP_SQRT; x_a0 = 8'd225;
        step();
        x_v0 = 1'b0;
        step();
        step();
        x_rst_n = 1'b0;
        step();
        x_rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen |= x_valid;
            step();
        end
        check("xrst.no_valid", seen, 1'b0);
        check("xrst.rsp", {x_id, x_carry, x_err, x_hi, x_lo}, 0);
        x_v0 = 1'b1; x_v1 = 1'b1;
        @(negedge clk);
        check("xrst.grant0", {x_r0, x_r1}, 2'b10);
        x_v0 = 1'b0; x_v1 = 1'b0;
        step();

`ifdef ARITH_EXT_STATS_EN
        check("stats.ops", stat_ops, 16'd11);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/arith_ext_arbiter.md
Name: arith_ext_arbiter

Overview:
Shares one instance each of the 8-bit `mul` and `sqrt` arithmetic-extension units between two requesters, such as two core issue ports.
- Arbitrates round-robin and captures the operands.
- Sequences a programmable execution delay, then returns one registered result over a valid/ready response channel tagged with the requester id.
- Sits between the core's execute stage and the arithmetic-extension datapath.

Parameters:
- EXEC_CYCLES, 1, cycles spent in BUSY before the result is captured; legal range 1..15.
- CNT_W, 4, width of the internal execution counter; must hold EXEC_CYCLES-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  2  opcode: 00 MUL, 01 SQRT, 10 SQR (a*a), 11 illegal.
- req0_a  in  8  operand A.
- req0_b  in  8  operand B (ignored for SQRT and SQR).
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that issued the operation.
- rsp_hi  out  8  result high byte.
- rsp_lo  out  8  result low byte.
- rsp_carry  out  1  product bit 16.
- rsp_err  out  1  illegal opcode flag.

Behaviour:
- Reset: when rst_n is low at a rising clk edge:
  - state goes to IDLE; rr_last = 1, so requester 0 wins the first contest;
  - rsp_valid, rsp_id, rsp_hi, rsp_lo, rsp_carry and rsp_err all go to 0;
  - the execution counter goes to 0.
- Reset mid-operation: a captured or pending operation is dropped and no response is ever produced.
- States:
  - IDLE -> BUSY on a request accept.
  - BUSY -> RESP when the counter reaches 0.
  - RESP -> IDLE on the rsp_valid & rsp_ready handshake.
- IDLE grant rule:
  - reqN_ready is combinational and equals (state==IDLE) & grant==N; it is never asserted outside IDLE.
  - Both valid: grant the requester that is not rr_last.
  - Only one valid: grant it.
- On accept:
  - latch op, a, b and id into internal registers;
  - set rr_last = granted id;
  - load counter = EXEC_CYCLES-1.
- BUSY:
  - counter decrements each cycle;
  - at counter==0, the combinational `mul`/`sqrt` outputs driven from the latched operands are registered into the rsp_* registers.
- Result mapping:
  - MUL: {carry,hi,lo} = a*b as a 17-bit value.
  - SQR: same as MUL with b replaced by a.
  - SQRT: lo = floor(sqrt(a)) (0..15), hi = 0, carry = 0.
  - illegal (11): hi = lo = carry = 0 and rsp_err = 1.
  - rsp_err = 0 for all legal opcodes.
- Latency: accept in cycle t gives rsp_valid = 1 in cycle t+1+EXEC_CYCLES.
- RESP:
  - rsp_* are held stable while rsp_ready is low, for any number of cycles.
  - rsp_valid falls in the cycle after the handshake.
- Throughput: the earliest next accept is the cycle after the handshake. There is no overlap, so there is one operation in flight at most.
- Requester inputs may change freely while reqN_ready is low; only the values present in the accept cycle are used.

Optional Feature:
- Macro: ARITH_EXT_STATS_EN.
- Defined:
  - adds output port stat_ops (16 bits), a count of completed response handshakes;
  - the count saturates at 0xFFFF and resets to 0;
  - illegal-opcode responses are counted.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package arith_ext_pkg:
  - opcode constants OP_MUL=2'b00, OP_SQRT=2'b01, OP_SQR=2'b10, OP_ILL=2'b11;
  - state enum {IDLE, BUSY, RESP};
  - DATA_W = 8.
- Sub-module rr_arb2: two-way round-robin grant logic taking the valids and rr_last, returning grant and grant_valid.
- The top level instantiates rr_arb2 plus the existing `mul` and `sqrt` units.

Test Plan:
- After reset, req0 MUL a=200 b=3 -> rsp_valid at accept+2 (EXEC_CYCLES=1), id=0, hi=0x02, lo=0x58, carry=0, err=0.
- req1 SQRT a=200 -> lo=14, hi=0, id=1. SQRT a=225 -> lo=15. SQRT a=0 -> lo=0.
- Both requesters valid continuously with rsp_ready=1:
  - grants alternate 0,1,0,1;
  - req0 SQR a=15 gives hi=0x00, lo=0xE1;
  - req1 MUL 255*255 gives hi=0xFE, lo=0x01.
- Opcode 11, a=7 -> err=1, hi=lo=0, carry=0. The next legal op then reports err=0.
- rsp_ready held low 5 cycles in RESP -> rsp_* stable and both reqN_ready=0 throughout. The handshake in cycle 6 leads to IDLE and a new accept is possible the following cycle.
- EXEC_CYCLES=4, rst_n low during BUSY -> rsp_valid stays 0, all rsp_* are 0, and the next contest is granted to requester 0.
